// File: rtl/hazard_ctrl.sv
`default_nettype none
// hazard_ctrl: operand forwarding, load-use/interlock stalls, branch flush, memory-wait stalls,
// debug halt/single-step FSM and saturating performance counters.  Revision: 1.0
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int FWD_EN     = 1,
  parameter int DELAY_SLOT = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug_en,
  input  logic              debug_step,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_is_store,
  input  logic              id_branch_taken,
  input  logic              exe_wen,
  input  logic [REG_AW-1:0] exe_waddr,
  input  logic              exe_is_load,
  input  logic              mem_wen,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic              mem_is_load,
  input  logic              mem_req,
  input  logic              mem_rdy,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              fwd_m,
  output logic              if_en,
  output logic              id_en,
  output logic              exe_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic              if_rst,
  output logic              id_rst,
  output logic              exe_rst,
  output logic              mem_rst,
  output logic              wb_rst,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  memwait_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam bit              FWD     = (FWD_EN != 0);
  localparam bit              DSLOT   = (DELAY_SLOT != 0);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t state;
  logic   debug_step_q;

  logic rs_hit_exe, rs_hit_mem, rt_hit_exe, rt_hit_mem;
  logic data_stall, mem_wait, in_halt, step_rise;
  logic do_memwait, do_stall, do_flush;

  assign rs_hit_exe = id_rs_used && (id_rs_addr != '0) && exe_wen && (exe_waddr == id_rs_addr);
  assign rs_hit_mem = id_rs_used && (id_rs_addr != '0) && mem_wen && (mem_waddr == id_rs_addr);
  assign rt_hit_exe = id_rt_used && (id_rt_addr != '0) && exe_wen && (exe_waddr == id_rt_addr);
  assign rt_hit_mem = id_rt_used && (id_rt_addr != '0) && mem_wen && (mem_waddr == id_rt_addr);

  always_comb begin
    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
    if (FWD) begin
      if (rs_hit_exe)      fwd_a_sel = 2'd1;
      else if (rs_hit_mem) fwd_a_sel = mem_is_load ? 2'd3 : 2'd2;
      if (rt_hit_exe)      fwd_b_sel = 2'd1;
      else if (rt_hit_mem) fwd_b_sel = mem_is_load ? 2'd3 : 2'd2;
    end
  end

  // A store whose data comes from the load just ahead picks it up in MEM, so only rs must wait.
  assign fwd_m = FWD && id_is_store && rt_hit_exe && exe_is_load;

  assign data_stall = FWD ? ((rs_hit_exe && exe_is_load) || (rt_hit_exe && exe_is_load && !fwd_m))
                          : (rs_hit_exe || rs_hit_mem || rt_hit_exe || rt_hit_mem);
  assign mem_wait   = mem_req && !mem_rdy;
  assign in_halt    = (state == HALT);
  assign step_rise  = debug_step && !debug_step_q;
  assign halted     = in_halt && !rst;

  assign do_memwait = !rst && !in_halt && mem_wait;
  assign do_stall   = !rst && !in_halt && !mem_wait && data_stall;
  assign do_flush   = !rst && !in_halt && !mem_wait && !data_stall && id_branch_taken && !DSLOT;

  always_comb begin
    {if_en, id_en, exe_en, mem_en, wb_en}       = 5'b11111;
    {if_rst, id_rst, exe_rst, mem_rst, wb_rst}  = 5'b00000;
    if (rst) begin
      {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b11111;
    end else if (in_halt) begin
      {if_en, id_en, exe_en, mem_en, wb_en} = 5'b00000;
    end else if (do_memwait) begin
      {if_en, id_en, exe_en, mem_en} = 4'b0000;
      wb_rst = 1'b1;
    end else if (do_stall) begin
      if_en   = 1'b0;
      id_en   = 1'b0;
      exe_rst = 1'b1;
    end else if (do_flush) begin
      id_rst = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      debug_step_q <= 1'b0;
    end else begin
      debug_step_q <= debug_step;
      case (state)
        RUN:     if (debug_en) state <= HALT;
        HALT: begin
          if (!debug_en)      state <= RUN;
          else if (step_rise) state <= STEP;
        end
        STEP:    state <= debug_en ? HALT : RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt   <= '0;
      memwait_cnt <= '0;
      flush_cnt   <= '0;
    end else begin
      if (do_stall && stall_cnt != '1)     stall_cnt   <= stall_cnt + CNT_ONE;
      if (do_memwait && memwait_cnt != '1) memwait_cnt <= memwait_cnt + CNT_ONE;
      if (do_flush && flush_cnt != '1)     flush_cnt   <= flush_cnt + CNT_ONE;
    end
  end

endmodule
`default_nettype wire
